act_pipe_unit: RTL and testbench
================================

Name: act_pipe_unit

Overview:
- Pipelined, multi-mode activation engine. Consumes LANES fixed-point values per beat from the systolic array output path and produces activated values with a valid/ready handshake.
- Generalises the combinational sigmoid stage. It adds run-time mode select (bypass/ReLU/sigmoid/tanh), a 3-stage pipeline with back-pressure, and vector framing via a last flag.

Parameters:
- DATA_WIDTH, 8, signed element width; values are fixed point with S fractional bits.
- LANES, 16, elements processed per beat.
- S, 7, fractional bits; legal range 1..DATA_WIDTH-1.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- in_data  input  LANES x DATA_WIDTH  signed input elements.
- in_mode  input  2  0 bypass, 1 ReLU, 2 sigmoid, 3 tanh; sampled with each beat.
- in_last  input  1  marks the final beat of a vector.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts a beat.
- out_data  output  LANES x DATA_WIDTH  signed results.
- out_last  output  1  in_last of the same beat, delayed.
- busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset: synchronous, active-high. All stage valids are cleared; out_valid=0, out_data=0, out_last=0, busy=0. In-flight beats are discarded. in_ready=1 from the first cycle after reset deasserts.
- Pipeline structure: stages S1 (abs/saturate), S2 (polynomial), S3 (sign fold/mode mux, registered output).
- Advance rule: advance = !s3_valid || out_ready. When advance=1, all stages shift together. When advance=0, all stages hold.
- Handshake: in_ready = advance. A beat is accepted when in_valid && in_ready.
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle.
- Stall: out_data and out_last stay stable while out_valid && !out_ready.
- Per-beat sideband: mode and last travel with their beat. A mode change between beats takes effect exactly at beat granularity; no flush is needed.
- Absolute value: a = |x|. For x = -2^(DATA_WIDTH-1), a = 2^(DATA_WIDTH-1)-1. Internal width is DATA_WIDTH+1 unsigned; squares use 2*(DATA_WIDTH+1) bits.
- Sigmoid core, poly(v):
  - If v >= 4*2^S: poly = 2^S-1.
  - Else: poly = 2^(S-1) + (v>>2) - ((v*v)>>(S+5)).
  - Result is always in [0, 2^S-1].
- Mode 0 (bypass): out = x.
- Mode 1 (ReLU): out = x if x >= 0, else 0.
- Mode 2 (sigmoid): y = poly(a). Output is y for x >= 0, and (2^S-1) - y for x < 0.
- Mode 3 (tanh):
  - a2 = 2*a, kept in the DATA_WIDTH+1 bit domain.
  - t = 2*poly(a2) - 2^S, clamped to [0, 2^S-1].
  - Output is t for x >= 0, and -t for x < 0.
- Lane independence: lanes are independent and bit-identical in function. Lane 0 maps to in_data[0].
- Simultaneous events: accept and emit in the same cycle is the normal steady state. rst has priority over all handshakes.
- Bubbles: in_valid=0 injects a bubble. Bubbles shift through and are collapsed only by the advance rule; there is no per-stage skid.
- busy = s1_valid | s2_valid | s3_valid.

Test Plan:
- Sigmoid, S=7: lanes {0, 100, -100, -128, 127} -> {64, 87, 40, 35, 92} on out_data. out_valid rises exactly 3 cycles after acceptance.
- ReLU/bypass/tanh interleaved on consecutive beats:
  - ReLU {-5, 37} -> {0, 37}.
  - Bypass {-5, 37} -> {-5, 37}.
  - Tanh {64, -64, 127, 0} -> {56, -56, 96, 0}.
  - Each beat uses its own mode with no bubbles.
- Back-pressure:
  - Push 5 beats back-to-back with out_ready=0 for cycles 2..7. in_ready falls once S3 is full.
  - out_data stays stable throughout the stall. All 5 results emerge in order with no loss or duplication after out_ready=1.
- Framing: a 4-beat vector with in_last on beat 4 -> out_last=1 only on output beat 4, including when a 2-cycle stall lands on beat 3.
- Reset mid-stream: rst=1 for one cycle with 2 beats in flight -> out_valid=0 and busy=0 the next cycle. Neither in-flight beat ever appears. A fresh beat afterwards has 3-cycle latency.
- Random sweep: all 256 input codes in all 4 modes through a random in_valid/out_ready pattern -> every output matches the bit-exact reference model.

Source files
------------

// File: rtl/act_pipe_unit.sv
// Three-stage activation pipeline: bypass / ReLU / sigmoid / tanh per beat.
// S1 takes the saturated magnitude, S2 evaluates the sigmoid polynomial, S3 folds the sign.
`timescale 1ns/1ps
module act_pipe_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 16,
    parameter int S          = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]    in_data,
    input  logic [1:0]                          in_mode,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES-1:0][DATA_WIDTH-1:0]    out_data,
    output logic                                out_last,
    output logic                                busy
);

    localparam int AW  = DATA_WIDTH + 1;
    localparam int SQW = 2 * AW;
    localparam int PW  = SQW + 2;

    localparam logic [1:0] MODE_BYP  = 2'd0;
    localparam logic [1:0] MODE_RELU = 2'd1;
    localparam logic [1:0] MODE_SIG  = 2'd2;
    localparam logic [1:0] MODE_TANH = 2'd3;

    localparam logic [DATA_WIDTH-1:0] X_MIN  = DATA_WIDTH'(1'b1) << (DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] X_MAX  = ~X_MIN;
    localparam logic [S-1:0]          Y_MAX  = {S{1'b1}};
    localparam logic [S-1:0]          Y_HALF = S'(1'b1) << (S - 1);
    localparam logic [AW:0]           V_SAT  = (AW + 1)'(3'd4) << S;
    localparam logic [S+2:0]          T_OFS  = (S + 3)'(1'b1) << S;

    // |x| with the most negative code saturated so it stays representable.
    function automatic logic [AW-1:0] abs_sat(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] neg;
        logic [AW-1:0]         res;
        neg = -x;
        if (x == X_MIN) res = AW'(X_MAX);
        else if (x[DATA_WIDTH-1]) res = AW'(neg);
        else res = AW'(x);
        return res;
    endfunction

    function automatic logic [S-1:0] poly(input logic [AW-1:0] v);
        logic [SQW-1:0] vx;
        logic [SQW-1:0] sq;
        logic [PW-1:0]  acc;
        logic [S-1:0]   res;
        vx  = SQW'(v);
        sq  = vx * vx;
        acc = PW'(Y_HALF) + PW'(v >> 2) - PW'(sq >> (S + 5));
        if ({1'b0, v} >= V_SAT) res = Y_MAX;
        else if (acc[PW-1]) res = S'(1'b0);
        else if (|acc[PW-2:S]) res = Y_MAX;
        else res = acc[S-1:0];
        return res;
    endfunction

    // Final per-lane result; tanh reuses the sigmoid core as 2*sig(2a) - 1.
    function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] x,
                                                   input logic [1:0]            mode,
                                                   input logic [S-1:0]          y);
        logic [S+2:0]          tw;
        logic [S-1:0]          t;
        logic [DATA_WIDTH-1:0] mag;
        logic [DATA_WIDTH-1:0] res;
        tw = {2'b00, y, 1'b0} - T_OFS;
        if (tw[S+2]) t = S'(1'b0);
        else if (tw[S+1:S] != 2'b00) t = Y_MAX;
        else t = tw[S-1:0];
        mag = DATA_WIDTH'(1'b0);
        case (mode)
            MODE_BYP:  res = x;
            MODE_RELU: res = x[DATA_WIDTH-1] ? DATA_WIDTH'(1'b0) : x;
            MODE_SIG: begin
                mag = x[DATA_WIDTH-1] ? DATA_WIDTH'(Y_MAX - y) : DATA_WIDTH'(y);
                res = mag;
            end
            MODE_TANH: begin
                mag = DATA_WIDTH'(t);
                res = x[DATA_WIDTH-1] ? -mag : mag;
            end
            default:   res = x;
        endcase
        return res;
    endfunction

    logic                                r_s1_valid, r_s1_last;
    logic [1:0]                          r_s1_mode;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_s1_x;
    logic [LANES-1:0][AW-1:0]            r_s1_v;
    logic                                r_s2_valid, r_s2_last;
    logic [1:0]                          r_s2_mode;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_s2_x;
    logic [LANES-1:0][S-1:0]             r_s2_y;
    logic                                r_s3_valid, r_s3_last;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_s3_data;

    logic                                w_advance;
    logic [LANES-1:0][AW-1:0]            w_s1_v;
    logic [LANES-1:0][S-1:0]             w_s2_y;
    logic [LANES-1:0][DATA_WIDTH-1:0]    w_s3_data;

    assign w_advance = !r_s3_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_s3_valid;
    assign out_data  = r_s3_data;
    assign out_last  = r_s3_last;
    assign busy      = r_s1_valid | r_s2_valid | r_s3_valid;

    // S1 operand: magnitude, doubled for tanh so S2 only ever evaluates poly(v).
    always_comb begin
        w_s1_v = '0;
        for (int l = 0; l < LANES; l++) begin
            if (in_mode == MODE_TANH) w_s1_v[l] = abs_sat(in_data[l]) << 1;
            else w_s1_v[l] = abs_sat(in_data[l]);
        end
    end

    // S2 polynomial per lane.
    always_comb begin
        w_s2_y = '0;
        for (int l = 0; l < LANES; l++) begin
            w_s2_y[l] = poly(r_s1_v[l]);
        end
    end

    // S3 sign fold and mode select per lane.
    always_comb begin
        w_s3_data = '0;
        for (int l = 0; l < LANES; l++) begin
            w_s3_data[l] = fold(r_s2_x[l], r_s2_mode, r_s2_y[l]);
        end
    end

    // Lock-step pipeline: every stage shifts on advance and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_mode  <= 2'd0;
            r_s1_x     <= '0;
            r_s1_v     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_mode  <= 2'd0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            r_s3_data  <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_last  <= in_last;
            r_s1_mode  <= in_mode;
            r_s1_x     <= in_data;
            r_s1_v     <= w_s1_v;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_mode  <= r_s1_mode;
            r_s2_x     <= r_s1_x;
            r_s2_y     <= w_s2_y;
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
            r_s3_data  <= w_s3_data;
        end
    end

endmodule

// File: tb/tb_act_pipe_unit.sv
// Bench for act_pipe_unit: arithmetic reference model + scoreboard, directed and random traffic.
`timescale 1ns/1ps
module tb_act_pipe_unit;
    localparam int DW    = 8;
    localparam int LANES = 16;
    localparam int S     = 7;
    localparam int VW    = LANES * DW;

    typedef logic [LANES-1:0][DW-1:0] vec_t;
    typedef struct { vec_t data; logic last; } exp_t;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy;
    logic [1:0] in_mode;
    vec_t       in_data, out_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic mon_en = 1'b0;
    logic stall_prev = 1'b0;
    vec_t prev_data;
    logic prev_last;

    act_pipe_unit #(.DATA_WIDTH(DW), .LANES(LANES), .S(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic int poly_m(input int v);
        if (v >= 4 * (1 << S)) return (1 << S) - 1;
        return (1 << (S - 1)) + v / 4 - (v * v) / (1 << (S + 5));
    endfunction

    function automatic int ref_lane(input int x, input int m);
        int a, y, t;
        a = (x < 0) ? -x : x;
        if (a > (1 << (DW - 1)) - 1) a = (1 << (DW - 1)) - 1;
        case (m)
            0: return x;
            1: return (x < 0) ? 0 : x;
            2: begin
                y = poly_m(a);
                return (x >= 0) ? y : ((1 << S) - 1 - y);
            end
            default: begin
                t = 2 * poly_m(2 * a) - (1 << S);
                if (t < 0) t = 0;
                if (t > (1 << S) - 1) t = (1 << S) - 1;
                return (x >= 0) ? t : -t;
            end
        endcase
    endfunction

    function automatic vec_t ref_beat(input vec_t d, input logic [1:0] m);
        vec_t r;
        int   v;
        for (int l = 0; l < LANES; l++) begin
            v    = ref_lane(int'($signed(d[l])), int'(m));
            r[l] = v[DW-1:0];
        end
        return r;
    endfunction

    function automatic vec_t mk(input int v0, input int v1, input int v2, input int v3, input int v4);
        vec_t r;
        int   vals[5];
        r    = '0;
        vals = '{v0, v1, v2, v3, v4};
        for (int i = 0; i < 5; i++) r[i] = vals[i][DW-1:0];
        return r;
    endfunction

    task automatic chk_lanes(input string nm, input int n, input int e0, input int e1,
                             input int e2, input int e3, input int e4);
        int   ev[5];
        logic [DW-1:0] e;
        ev = '{e0, e1, e2, e3, e4};
        for (int l = 0; l < n; l++) begin
            e = ev[l][DW-1:0];
            chk($sformatf("%s_lane%0d", nm, l), VW'(out_data[l]), VW'(e));
        end
    endtask

    task automatic cyc_drive(input logic v, input vec_t d, input logic [1:0] m,
                             input logic l, input logic rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        in_last   = l;
        out_ready = rdy;
    endtask

    // Single compare process: scoreboard, handshake rule, busy and stall stability.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", VW'(busy), VW'(sb.size() != 0));
            chk("in_ready", VW'(in_ready), VW'(!out_valid || out_ready));
            if (stall_prev) begin
                chk("stall_valid", VW'(out_valid), VW'(1'b1));
                chk("stall_data", VW'(out_data), VW'(prev_data));
                chk("stall_last", VW'(out_last), VW'(prev_last));
            end
            if (rst) begin
                sb.delete();
                stall_prev = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", VW'(out_valid), VW'(1'b0));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out_data", VW'(out_data), VW'(e.data));
                        chk("out_last", VW'(out_last), VW'(e.last));
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                if (in_valid && in_ready) begin
                    exp_t n;
                    n.data = ref_beat(in_data, in_mode);
                    n.last = in_last;
                    sb.push_back(n);
                end
            end
        end
    end

    task automatic sig_latency(input string nm);
        cyc_drive(1'b1, mk(0, 100, -100, -128, 127), 2'd2, 1'b0, 1'b1);
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        chk({nm, "_c1"}, VW'(out_valid), VW'(1'b0));
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        chk({nm, "_c2"}, VW'(out_valid), VW'(1'b0));
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        chk({nm, "_c3"}, VW'(out_valid), VW'(1'b1));
        chk_lanes(nm, 5, 64, 87, 40, 35, 92);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t bp[5];
        vec_t held;
        exp_t seq[$];
        int   idx, j;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; in_last = 1'b0; out_ready = 1'b1;

        chk("model_sig_100", VW'(ref_lane(100, 2)), VW'(87));
        chk("model_sig_m128", VW'(ref_lane(-128, 2)), VW'(35));
        chk("model_tanh_m64", VW'(ref_lane(-64, 3)), VW'(-56));
        chk("model_tanh_127", VW'(ref_lane(127, 3)), VW'(96));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", VW'(out_valid), VW'(1'b0));
        chk("rst_out_data", VW'(out_data), VW'(0));
        chk("rst_out_last", VW'(out_last), VW'(1'b0));
        chk("rst_busy", VW'(busy), VW'(1'b0));
        chk("rst_in_ready", VW'(in_ready), VW'(1'b1));
        mon_en = 1'b1;

        sig_latency("sig");

        // Mixed modes on consecutive beats.
        cyc_drive(1'b1, mk(-5, 37, 0, 0, 0), 2'd1, 1'b0, 1'b1);
        cyc_drive(1'b1, mk(-5, 37, 0, 0, 0), 2'd0, 1'b0, 1'b1);
        cyc_drive(1'b1, mk(64, -64, 127, 0, 0), 2'd3, 1'b0, 1'b1);
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        chk("relu_valid", VW'(out_valid), VW'(1'b1));
        chk_lanes("relu", 2, 0, 37, 0, 0, 0);
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        chk("byp_valid", VW'(out_valid), VW'(1'b1));
        chk_lanes("byp", 2, -5, 37, 0, 0, 0);
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        chk("tanh_valid", VW'(out_valid), VW'(1'b1));
        chk_lanes("tanh", 4, 56, -56, 96, 0, 0);

        // Back-pressure: 5 beats, out_ready low for cycles 2..7.
        for (int i = 0; i < 5; i++) bp[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        idx  = 0;
        held = '0;
        j    = 1;
        while (j <= 40 && !(idx == 5 && sb.size() == 0 && j > 8)) begin
            cyc_drive(idx < 5, bp[(idx < 5) ? idx : 0], 2'(idx), 1'b0, !(j >= 2 && j <= 7));
            @(negedge clk);
            if (j == 4) held = out_data;
            if (j >= 4 && j <= 7) chk("bp_in_ready_low", VW'(in_ready), VW'(1'b0));
            if (j == 7) begin
                chk("bp_held_data", VW'(out_data), VW'(held));
                chk("bp_accepted", VW'(idx), VW'(3));
            end
            if (in_valid && in_ready) idx++;
            j++;
        end
        chk("bp_drained", VW'(idx == 5 && sb.size() == 0), VW'(1'b1));

        // Framing: 4-beat vector, 2-cycle stall while output beat 3 is presented.
        for (int k = 1; k <= 12; k++) begin
            cyc_drive(k <= 4, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(3)),
                      k == 4, !(k == 6 || k == 7));
            @(negedge clk);
            if (k == 6) chk("frame_b3_last", VW'({out_valid, out_last}), VW'(2'b10));
            if (k == 8) chk("frame_b3_rel", VW'({out_valid, out_last}), VW'(2'b10));
            if (k == 9) chk("frame_b4_last", VW'({out_valid, out_last}), VW'(2'b11));
        end

        // Reset with two beats in flight.
        cyc_drive(1'b1, mk(10, 20, 30, 40, 50), 2'd2, 1'b0, 1'b1);
        cyc_drive(1'b1, mk(-10, -20, -30, -40, -50), 2'd3, 1'b1, 1'b1);
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        rst = 1'b1;
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        rst = 1'b0;
        chk("rstmid_out_valid", VW'(out_valid), VW'(1'b0));
        chk("rstmid_busy", VW'(busy), VW'(1'b0));
        for (int k = 0; k < 4; k++) begin
            cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
            chk("rstmid_quiet", VW'(out_valid), VW'(1'b0));
        end
        sig_latency("sig_after_rst");

        // Random sweep: every code in every mode, plus random beats, random handshakes.
        for (int m = 0; m < 4; m++) begin
            for (int g = 0; g < 16; g++) begin
                exp_t b;
                for (int l = 0; l < LANES; l++) b.data[l] = 8'(g * 16 + l);
                b.last = (g == 15);
                b.data = b.data;
                seq.push_back(b);
            end
        end
        for (int k = 0; k < 40; k++) begin
            exp_t b;
            b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
            b.last = 1'($urandom_range(1));
            seq.push_back(b);
        end
        idx = 0;
        j   = 0;
        while ((idx < seq.size() || sb.size() != 0) && j < 3000) begin
            logic       v;
            logic [1:0] md;
            v  = (idx < seq.size()) && ($urandom_range(99) < 75);
            md = (idx < 64) ? 2'(idx / 16) : 2'($urandom_range(3));
            cyc_drive(v, v ? seq[idx].data : '0, md, v ? seq[idx].last : 1'b0,
                      $urandom_range(99) < 70);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            j++;
        end
        chk("sweep_complete", VW'(idx == seq.size() && sb.size() == 0), VW'(1'b1));

        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        cyc_drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
